// File: rtl/pixel_fifo_dither_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo_dither_pkg
// Brief    : RGB332 field slices, 2-bit-per-channel output type and the
//            saturating 2x2 ordered-dither helpers.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_fifo_dither_pkg;

  // RGB332 byte layout: {R[2:0], G[2:0], B[1:0]}
  localparam int c_R_MSB = 7;
  localparam int c_R_LSB = 5;
  localparam int c_G_MSB = 4;
  localparam int c_G_LSB = 2;
  localparam int c_B_MSB = 1;
  localparam int c_B_LSB = 0;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  // Drop the channel LSB, add it back as a dither bias, clamp to 3.
  function automatic logic [1:0] sat3(input logic [2:0] ch, input logic d);
    logic [2:0] w_sum;
    w_sum = {1'b0, ch[2:1]} + {2'b00, ch[0] & d};
    return (w_sum > 3'd3) ? 2'd3 : w_sum[1:0];
  endfunction

  // Reduce an RGB332 pixel to RGB222; blue already has two bits.
  function automatic rgb222_t dither332(input logic [7:0] px, input logic d);
    rgb222_t w_o;
    w_o.r = sat3(px[c_R_MSB:c_R_LSB], d);
    w_o.g = sat3(px[c_G_MSB:c_G_LSB], d);
    w_o.b = px[c_B_MSB:c_B_LSB];
    return w_o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fifo_dither_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo_dither_if
// Brief    : Pixel input strobe, display timing taps and RGB222 / status
//            outputs of the pixel FIFO + dither block.
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_fifo_dither_if #(
  parameter int DEPTH = 8
);
  localparam int c_LVL_W = $clog2(DEPTH) + 1;

  logic [7:0]         in_data;
  logic               in_valid;
  logic               flush;
  logic               active;
  logic               x0;
  logic               y0;
  logic               almost_full;
  logic [c_LVL_W-1:0] level;
  logic [1:0]         r_out;
  logic [1:0]         g_out;
  logic [1:0]         b_out;
  logic               underflow;
  logic               overflow;

  // Reader / timing generator side
  modport master (
    output in_data, in_valid, flush, active, x0, y0,
    input  almost_full, level, r_out, g_out, b_out, underflow, overflow
  );

  // FIFO + dither block side
  modport slave (
    input  in_data, in_valid, flush, active, x0, y0,
    output almost_full, level, r_out, g_out, b_out, underflow, overflow
  );

endinterface
`default_nettype wire

// File: rtl/pixel_fifo_dither_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo_dither_sync_fifo
// Brief    : DEPTH x WIDTH synchronous FIFO with separate occupancy count,
//            full/empty flags and a synchronous flush. Head is combinational.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fifo_dither_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       i_flush,
  input  wire logic                       i_wr_en,
  input  wire logic [WIDTH-1:0]           i_wr_data,
  input  wire logic                       i_rd_en,
  output logic      [WIDTH-1:0]           o_rd_data,
  output logic      [$clog2(DEPTH):0]     o_count,
  output logic                            o_full,
  output logic                            o_empty
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_wr;
  logic               w_rd;

  // Guard against pushing into full / popping from empty; flush wins over both.
  assign w_wr = i_wr_en && !o_full  && !i_flush;
  assign w_rd = i_rd_en && !o_empty && !i_flush;

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy count, unchanged on simultaneous push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = (r_count == c_CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pixel_fifo_dither.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo_dither
// Brief    : Buffers bursty RGB332 pixels from the flash reader, repeats each
//            pixel H_REPEAT display clocks, applies 2x2 ordered dither down to
//            RGB222 and registers the result for the VGA pins.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_fifo_dither
  import pixel_fifo_dither_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int H_REPEAT = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pixel_fifo_dither_if.slave bus
);
  localparam int         c_CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [1:0] c_REP_LAST = 2'(H_REPEAT - 1);

  logic [1:0]         r_rep;
  logic               r_underflow;
  logic               r_overflow;
  rgb222_t            r_pix;

  logic [7:0]         w_head;
  logic [c_CNT_W-1:0] w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_pop_due;
  logic               w_wr_en;
  logic               w_rd_en;
  rgb222_t            w_pix_next;

  // A source pixel is retired on the last repeat slot of an active clock.
  assign w_pop_due = bus.active && (r_rep == c_REP_LAST);
  assign w_wr_en   = bus.in_valid && !w_full  && !bus.flush;
  assign w_rd_en   = w_pop_due    && !w_empty && !bus.flush;

  pixel_fifo_dither_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (bus.flush),
    .i_wr_en   (w_wr_en),
    .i_wr_data (bus.in_data),
    .i_rd_en   (w_rd_en),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Horizontal repeat counter: advances on active clocks, cleared by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep <= '0;
    end else if (bus.flush) begin
      r_rep <= '0;
    end else if (bus.active) begin
      r_rep <= (r_rep == c_REP_LAST) ? 2'd0 : r_rep + 2'd1;
    end
  end

  // Sticky error flags; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_pop_due && w_empty && !bus.flush)      r_underflow <= 1'b1;
      if (bus.in_valid && w_full && !bus.flush)    r_overflow  <= 1'b1;
    end
  end

  // Next output pixel: dithered head when displaying, black when blanking,
  // starved, or discarding the line with flush.
  always_comb begin
    w_pix_next = '0;
    if (bus.active && !w_empty && !bus.flush) begin
      w_pix_next = dither332(w_head, bus.x0 ^ bus.y0);
    end
  end

  // Output register, one clock of latency to the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix <= '0;
    end else begin
      r_pix <= w_pix_next;
    end
  end

  assign bus.r_out       = r_pix.r;
  assign bus.g_out       = r_pix.g;
  assign bus.b_out       = r_pix.b;
  assign bus.underflow   = r_underflow;
  assign bus.overflow    = r_overflow;
  assign bus.level       = w_count;
  assign bus.almost_full = (w_count >= c_CNT_W'(DEPTH - 2));

endmodule
`default_nettype wire

// File: tb/tb_pixel_fifo_dither.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_fifo_dither
// Brief    : Self-checking bench for pixel_fifo_dither against a queue-based
//            reference model of the pixel buffer, repeat and dither rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_fifo_dither;
  localparam int DEPTH = 8;
  localparam int HREP  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_fifo_dither_if #(.DEPTH(DEPTH)) bus ();

  pixel_fifo_dither #(.DEPTH(DEPTH), .H_REPEAT(HREP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  logic [7:0] q[$];
  int         m_rep;
  bit         m_uf;
  bit         m_of;
  logic [5:0] m_out;

  int n_vec = 0;
  int n_err = 0;

  // Expected RGB222 of a pixel from plain channel arithmetic.
  function automatic logic [5:0] ref_pix(input logic [7:0] p, input bit d);
    int r, g, b, ro, go;
    r  = int'(p) / 32;
    g  = (int'(p) / 4) % 8;
    b  = int'(p) % 4;
    ro = r / 2 + ((d && (r % 2 == 1)) ? 1 : 0);
    go = g / 2 + ((d && (g % 2 == 1)) ? 1 : 0);
    if (ro > 3) ro = 3;
    if (go > 3) go = 3;
    return {2'(ro), 2'(go), 2'(b)};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {bus.r_out, bus.g_out, bus.b_out, bus.level,
            bus.almost_full, bus.underflow, bus.overflow};
  endfunction

  function automatic logic [12:0] model_vec();
    return {m_out, 4'(q.size()), 1'(q.size() >= DEPTH - 2), 1'(m_uf), 1'(m_of)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_rep = 0;
    m_uf  = 0;
    m_of  = 0;
    m_out = '0;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit a,
                       input bit x, input bit y, input bit f);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.active   = a;
    bus.x0       = x;
    bus.y0       = y;
    bus.flush    = f;
  endtask

  // Advance one clock: the model consumes the inputs present before the edge.
  task automatic tick();
    logic [5:0] nxt;
    int         sz;
    bit         pop_due;
    sz  = q.size();
    nxt = '0;
    if (!bus.flush && bus.active && sz > 0) nxt = ref_pix(q[0], bus.x0 ^ bus.y0);
    if (bus.flush) begin
      q.delete();
      m_rep = 0;
    end else begin
      pop_due = bus.active && (m_rep == HREP - 1);
      if (pop_due && sz == 0) m_uf = 1;
      if (bus.in_valid && sz == DEPTH) m_of = 1;
      if (pop_due && sz > 0) void'(q.pop_front());
      if (bus.in_valid && sz < DEPTH) q.push_back(bus.in_data);
      if (bus.active) m_rep = (m_rep + 1) % HREP;
    end
    @(posedge clk);
    #1;
    m_out = nxt;
  endtask

  task automatic do_reset();
    drive(0, 8'h00, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'($urandom), i >= 2, 1'($urandom), 1'($urandom), 0);
      tick();
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL reset_burst[%0d]: dut=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    drive(1, 8'hFF, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if (dut_vec() !== 13'd0) begin
      n_err++;
      $display("FAIL reset_async: dut=%h exp=%h", dut_vec(), 13'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 8'h00, 0, 0, 0, 0);
    tick();
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++;
      $display("FAIL reset_release: dut=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] px [3];
    logic [5:0] exp_tab [8];
    px      = '{8'hFF, 8'h00, 8'h03};
    exp_tab = '{6'b111111, 6'b111111, 6'b000000, 6'b000000,
                6'b000011, 6'b000011, 6'b000000, 6'b000000};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, px[i], 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 8'h00, 1, 0, 0, 0);
      tick();
      n_vec++;
      if (dut_vec() !== model_vec() || {bus.r_out, bus.g_out, bus.b_out} !== exp_tab[i]) begin
        n_err++;
        $display("FAIL fill_drain[%0d]: dut=%h exp=%h rgb=%b exp_rgb=%b", i,
                 dut_vec(), model_vec(), {bus.r_out, bus.g_out, bus.b_out}, exp_tab[i]);
      end
    end
  endtask

  task automatic test_dither();
    logic [7:0] px [3];
    logic [1:0] xy [6];
    logic [5:0] exp_tab [6];
    logic [1:0] cur;
    // 0x49 has R0=G0=0 so its dither bias never applies.
    px      = '{8'h49, 8'h6D, 8'hE0};
    xy      = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01};
    exp_tab = '{6'b010101, 6'b010101, 6'b010101, 6'b101001, 6'b110000, 6'b110000};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, px[i], 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      cur = xy[i];
      drive(0, 8'h00, 1, cur[1], cur[0], 0);
      tick();
      n_vec++;
      if (dut_vec() !== model_vec() || {bus.r_out, bus.g_out, bus.b_out} !== exp_tab[i]) begin
        n_err++;
        $display("FAIL dither[%0d]: dut=%h exp=%h rgb=%b exp_rgb=%b", i,
                 dut_vec(), model_vec(), {bus.r_out, bus.g_out, bus.b_out}, exp_tab[i]);
      end
    end
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 1) == 1) && (q.size() < DEPTH - 2), 8'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 0);
      tick();
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL dither_rand[%0d]: dut=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(1, 8'($urandom), 0, 0, 0, 0);
      tick();
      n_vec++;
      if (dut_vec() !== model_vec() || bus.almost_full !== (i >= 6) ||
          bus.level !== 4'((i > 8) ? 8 : i) || bus.overflow !== (i == 9)) begin
        n_err++;
        $display("FAIL backpressure[%0d]: dut=%h exp=%h level=%0d af=%b of=%b", i,
                 dut_vec(), model_vec(), bus.level, bus.almost_full, bus.overflow);
      end
    end
  endtask

  task automatic test_underflow();
    logic [7:0] px;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 8'h00, 1, 0, 0, 0);
      tick();
    end
    n_vec++;
    if (dut_vec() !== model_vec() || bus.underflow !== 1'b1 ||
        {bus.r_out, bus.g_out, bus.b_out} !== 6'd0) begin
      n_err++;
      $display("FAIL underflow_set: dut=%h exp=%h uf=%b", dut_vec(), model_vec(), bus.underflow);
    end
    px = 8'($urandom);
    drive(1, px, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 1, 0, 0, 0);
      tick();
      n_vec++;
      if (dut_vec() !== model_vec() ||
          {bus.r_out, bus.g_out, bus.b_out} !== ((i < 2) ? ref_pix(px, 0) : 6'd0)) begin
        n_err++;
        $display("FAIL underflow_recover[%0d]: dut=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_flush();
    logic [7:0] b1, b2;
    logic [5:0] want;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'($urandom), 0, 0, 0, 0);
      tick();
    end
    drive(0, 8'h00, 1, 0, 0, 0);
    tick();
    drive(1, 8'($urandom), 0, 0, 0, 1);
    tick();
    n_vec++;
    if (dut_vec() !== model_vec() || bus.level !== 4'd0) begin
      n_err++;
      $display("FAIL flush_level: dut=%h exp=%h level=%0d", dut_vec(), model_vec(), bus.level);
    end
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    drive(1, b1, 0, 0, 0, 0);
    tick();
    drive(1, b2, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 1, 0, 1, 0);
      tick();
      want = ref_pix((i < 2) ? b1 : b2, 1);
      n_vec++;
      if (dut_vec() !== model_vec() || {bus.r_out, bus.g_out, bus.b_out} !== want) begin
        n_err++;
        $display("FAIL flush_after[%0d]: dut=%h exp=%h rgb=%b exp_rgb=%b", i,
                 dut_vec(), model_vec(), {bus.r_out, bus.g_out, bus.b_out}, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
            1'($urandom), 1'($urandom), $urandom_range(0, 39) == 0);
      tick();
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++;
        $display("FAIL random[%0d]: dut=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    drive(0, 8'h00, 0, 0, 0, 0);
    test_reset();
    test_fill_drain();
    test_dither();
    test_backpressure();
    test_underflow();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
